alu_issue: RTL and testbench
============================

# alu_issue

Execute-stage sequencer sitting directly upstream of the core's combinational `alu`. Accepts one operation (op1, op2, func) from decode via valid/ready, drives the ALU from registered operands, and holds multi-cycle paths for `mul`/`div`. Captures result, owns the architectural flags register (above/equals/overflow) that feeds `alu.flags_in`, and presents the result downstream via valid/ready.

## Interface
- `WIDTH`, 32, operand/result width.
- `MULDIV_CYCLES`, 4, cycles the ALU inputs are held before capture for `mul`/`div`; legal range ≥1.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  decode offers an operation.
- `in_ready`  out  1  block can accept this cycle.
- `in_op1`, `in_op2`  in  WIDTH  signed operands.
- `in_func`  in  6  function code.
- `alu_op1`, `alu_op2`  out  WIDTH  registered operands to ALU.
- `alu_func`  out  6  registered function to ALU.
- `alu_flags_in`  out  3  current flags register to ALU.
- `alu_result`  in  WIDTH  ALU result.
- `alu_flags_out`  in  3  ALU flags {above, equals, overflow}.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes result.
- `out_result`  out  WIDTH  captured result.
- `flags`  out  3  architectural flags register, bit 2 above, bit 1 equals, bit 0 overflow.
- `flags_clear`  in  1  synchronous clear of flags register.

## Operation
- Function codes: add 100000, sub 100010, mul 011000, div 011010, and 100100, or 100101, not 100111, brfl 111111.
- States: IDLE, EXEC, DONE.
- IDLE: `in_ready`=1. On `in_valid`, latch operands/func into operand regs and go to EXEC. Load counter with MULDIV_CYCLES-1 for mul/div, 0 otherwise.
- EXEC: `in_ready`=0. `alu_*` driven from operand regs. Counter ≠0: decrement, stay. Counter =0: capture `alu_result` into `out_result`, go to DONE.
- Flag write at the same capture edge: add, sub, mul and div load `flags` ← `alu_flags_out`. and, or, not and brfl leave `flags` unchanged. brfl only reads flags via `alu_flags_in`.
- Unknown func: single-cycle, result captured as the ALU gives it, no flag write.
- DONE: `out_valid`=1, `out_result` stable until handshake. `in_ready` = `out_ready`.
  - `out_ready` with `in_valid`: accept the new operation in the same cycle and go to EXEC (back-to-back).
  - `out_ready` only: go to IDLE.
  - no `out_ready`: hold.
- `flags_clear`=1 at an edge: `flags` ← 000. Clear takes priority over a coincident flag write. Legal in any state.
- `alu_op*`/`alu_func` change only on acceptance; they are stable throughout EXEC.

## Timing
- Reset (async, immediate on `rst_n`=0): state IDLE, `in_ready`=1, `out_valid`=0, `out_result`=0, `flags`=000, `alu_op1`/`alu_op2`=0, `alu_func`=000000, counter 0.
- Reset mid-operation aborts the transaction. No `out_valid` follows, and flags are not written.
- Acceptance at edge E:
  - `out_valid` rises after edge E+1 for single-cycle functions.
  - `out_valid` rises after edge E+MULDIV_CYCLES for mul/div.
- Back-to-back throughput: one single-cycle op per 2 cycles with `out_ready` held high.
- Flags written at the capture edge are visible on `flags`/`alu_flags_in` from the next cycle. A following brfl sees them.
- MULDIV_CYCLES=1: mul/div timing is identical to single-cycle functions.

## Test plan
- add op1=0x7FFFFFFF, op2=0x00000001, `out_ready`=1 -> `out_valid` 1 cycle after acceptance, `out_result`=0x80000000, `flags[0]`=1.
- mul op1=6, op2=7 with MULDIV_CYCLES=4 -> `alu_op*` stable for 4 cycles. `out_valid` rises exactly 4 cycles after acceptance with `out_result`=42. `in_ready`=0 throughout.
- sub 5-5 sets `flags[1]`=1. Then and 0xF0F0F0F0 & 0x0FF00FF0 -> `out_result`=0x00F000F0, `flags` unchanged.
- Backpressure: result ready with `out_ready`=0 for 5 cycles -> `out_valid` and `out_result` held, `in_ready`=0. Then `out_ready`=1 with `in_valid`=1 -> next op accepted in the same cycle.
- `flags_clear` asserted on the same edge as add's flag capture -> `flags`=000 afterwards, `out_result` correct.
- `rst_n` pulled low in the 2nd EXEC cycle of div -> `out_valid`=0 and `flags`=000 immediately. After release, `in_ready`=1 and no stale result appears.

Source files
------------

// File: rtl/alu_issue.sv
// Execute-stage sequencer: registers one decoded op, holds it on the ALU for 1 or MULDIV_CYCLES
// cycles, captures result and owns the flags register; valid/ready on both sides.
module alu_issue #(
  parameter int WIDTH         = 32,
  parameter int MULDIV_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_op1,
  input  logic [WIDTH-1:0] in_op2,
  input  logic [5:0]       in_func,
  output logic [WIDTH-1:0] alu_op1,
  output logic [WIDTH-1:0] alu_op2,
  output logic [5:0]       alu_func,
  output logic [2:0]       alu_flags_in,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [2:0]       alu_flags_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [2:0]       flags,
  input  logic             flags_clear
);

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_MUL = 6'b011000;
  localparam logic [5:0] F_DIV = 6'b011010;
  localparam int CW = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] op1_q;
  logic [WIDTH-1:0] op2_q;
  logic [WIDTH-1:0] result_q;
  logic [5:0]       func_q;
  logic [2:0]       flags_q;

  logic accept;
  logic in_is_muldiv;
  logic capture;
  logic writes_flags;

  // DONE accepts a new op in the same cycle the result is taken (back-to-back).
  assign in_ready     = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept       = in_valid && in_ready;
  assign in_is_muldiv = (in_func == F_MUL) || (in_func == F_DIV);
  assign capture      = (state_q == EXEC) && (cnt_q == '0);
  assign writes_flags = (func_q == F_ADD) || (func_q == F_SUB) ||
                        (func_q == F_MUL) || (func_q == F_DIV);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      func_q   <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      if (accept) begin
        op1_q   <= in_op1;
        op2_q   <= in_op2;
        func_q  <= in_func;
        cnt_q   <= in_is_muldiv ? CW'(MULDIV_CYCLES - 1) : '0;
        state_q <= EXEC;
      end else begin
        case (state_q)
          EXEC: begin
            if (cnt_q != '0) begin
              cnt_q <= cnt_q - CW'(1);
            end else begin
              result_q <= alu_result;
              state_q  <= DONE;
            end
          end
          DONE: begin
            if (out_ready) state_q <= IDLE;
          end
          default: ;
        endcase
      end
      // Clear wins over a flag write landing on the same edge.
      if (flags_clear) begin
        flags_q <= '0;
      end else if (capture && writes_flags) begin
        flags_q <= alu_flags_out;
      end
    end
  end

  assign alu_op1      = op1_q;
  assign alu_op2      = op2_q;
  assign alu_func     = func_q;
  assign alu_flags_in = flags_q;
  assign flags        = flags_q;
  assign out_valid    = (state_q == DONE);
  assign out_result   = result_q;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: behavioural ALU, scoreboard queue of expected result/flags.
module tb_alu_issue;

  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_MUL  = 6'b011000;
  localparam logic [5:0] F_DIV  = 6'b011010;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_NOT  = 6'b100111;
  localparam logic [5:0] F_BRFL = 6'b111111;

  typedef struct packed {
    logic [31:0] res;
    logic [2:0]  fl;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_op1, in_op2;
  logic [5:0]  in_func;
  logic [31:0] alu_op1, alu_op2;
  logic [5:0]  alu_func;
  logic [2:0]  alu_flags_in;
  logic [31:0] alu_result;
  logic [2:0]  alu_flags_out;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [2:0]  flags;
  logic        flags_clear;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic [2:0] exp_flags = 3'b000;
  exp_t sb_q[$];

  alu_issue #(.WIDTH(32), .MULDIV_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op1(in_op1), .in_op2(in_op2), .in_func(in_func),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_func(alu_func),
    .alu_flags_in(alu_flags_in), .alu_result(alu_result), .alu_flags_out(alu_flags_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .flags(flags), .flags_clear(flags_clear)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference ALU: {above, equals, overflow, result}
  function automatic logic [34:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [5:0] f, input logic [2:0] fin);
    logic signed [31:0] sa, sb;
    logic signed [63:0] p;
    logic [31:0] r;
    logic ov;
    sa = a; sb = b; r = '0; ov = 1'b0; p = '0;
    case (f)
      F_ADD: begin r = a + b; ov = (a[31] == b[31]) && (r[31] != a[31]); end
      F_SUB: begin r = a - b; ov = (a[31] != b[31]) && (r[31] != a[31]); end
      F_MUL: begin
        p  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        r  = p[31:0];
        ov = (p != {{32{r[31]}}, r});
      end
      F_DIV: begin
        if (b == 32'd0) r = '1;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin r = a; ov = 1'b1; end
        else r = 32'(sa / sb);
      end
      F_AND:  r = a & b;
      F_OR:   r = a | b;
      F_NOT:  r = ~a;
      F_BRFL: r = {29'd0, fin};
      default: r = a ^ b;
    endcase
    return {(sa > sb), (a == b), ov, r};
  endfunction

  logic [34:0] alu_model;
  always_comb alu_model = ref_alu(alu_op1, alu_op2, alu_func, alu_flags_in);
  assign alu_result    = alu_model[31:0];
  assign alu_flags_out = alu_model[34:32];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one op, wait (bounded) for acceptance, and push its expected outcome.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [5:0] f);
    logic [34:0] m;
    exp_t e;
    int n;
    in_op1 = a; in_op2 = b; in_func = f; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    m = ref_alu(a, b, f, exp_flags);
    if (f == F_ADD || f == F_SUB || f == F_MUL || f == F_DIV) exp_flags = m[34:32];
    e.res = m[31:0];
    e.fl  = exp_flags;
    sb_q.push_back(e);
    tick();
    in_valid = 1'b0;
  endtask

  // Cycles from acceptance until out_valid; -1 if it never came.
  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    if (!out_valid) n = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_op1 = '0; in_op2 = '0; in_func = '0;
    out_ready = 1'b0; flags_clear = 1'b0;
    repeat (3) tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_result !== 32'd0) begin errors++; $display("FAIL reset_out_result got %h want 0", out_result); end
    checks++; if (flags !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", flags); end
    checks++;
    if (alu_op1 !== 32'd0 || alu_op2 !== 32'd0 || alu_func !== 6'd0) begin
      errors++; $display("FAIL reset_alu_regs got %h %h %b want 0 0 0", alu_op1, alu_op2, alu_func);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_add_overflow();
    int n;
    exp_t e;
    out_ready = 1'b1;
    issue(32'h7FFF_FFFF, 32'h0000_0001, F_ADD);
    wait_valid(n);
    e = sb_q.pop_front();
    checks++; if (n != 1) begin errors++; $display("FAIL add_latency got %0d want 1", n); end
    checks++; if (out_result !== 32'h8000_0000) begin errors++; $display("FAIL add_result got %h want 80000000", out_result); end
    checks++; if (flags !== 3'b101 || flags !== e.fl) begin errors++; $display("FAIL add_flags got %b want 101", flags); end
    tick();
  endtask

  task automatic test_mul_hold();
    int n;
    int bad;
    exp_t e;
    out_ready = 1'b1;
    issue(32'd6, 32'd7, F_MUL);
    n = 0; bad = 0;
    while (!out_valid && n < 20) begin
      if (alu_op1 !== 32'd6 || alu_op2 !== 32'd7 || alu_func !== F_MUL || in_ready !== 1'b0) bad++;
      tick(); n++;
    end
    e = sb_q.pop_front();
    checks++; if (bad != 0) begin errors++; $display("FAIL mul_hold unstable_cycles got %0d want 0", bad); end
    checks++; if (n != 4) begin errors++; $display("FAIL mul_latency got %0d want 4", n); end
    checks++; if (out_result !== 32'd42) begin errors++; $display("FAIL mul_result got %0d want 42", out_result); end
    checks++; if (flags !== e.fl) begin errors++; $display("FAIL mul_flags got %b want %b", flags, e.fl); end
    tick();
  endtask

  task automatic test_sub_and();
    int n;
    exp_t e;
    out_ready = 1'b1;
    issue(32'd5, 32'd5, F_SUB);
    wait_valid(n);
    e = sb_q.pop_front();
    checks++; if (out_result !== e.res || flags !== 3'b010) begin
      errors++; $display("FAIL sub_eq got %h/%b want %h/010", out_result, flags, e.res);
    end
    tick();
    issue(32'hF0F0_F0F0, 32'h0FF0_0FF0, F_AND);
    wait_valid(n);
    e = sb_q.pop_front();
    checks++; if (out_result !== 32'h00F0_00F0) begin errors++; $display("FAIL and_result got %h want 00F000F0", out_result); end
    checks++; if (flags !== 3'b010 || flags !== e.fl) begin errors++; $display("FAIL and_flags got %b want 010", flags); end
    tick();
  endtask

  task automatic test_unknown_func();
    int n;
    exp_t e;
    out_ready = 1'b1;
    issue(32'h0000_000F, 32'h0000_00F3, 6'b000001);
    wait_valid(n);
    e = sb_q.pop_front();
    checks++; if (n != 1) begin errors++; $display("FAIL unk_latency got %0d want 1", n); end
    checks++; if (out_result !== 32'h0000_00FC || flags !== e.fl) begin
      errors++; $display("FAIL unk_result got %h/%b want 000000FC/%b", out_result, flags, e.fl);
    end
    tick();
  endtask

  task automatic test_backpressure();
    int n;
    int bad;
    exp_t e;
    out_ready = 1'b0;
    issue(32'd3, 32'd4, F_ADD);
    wait_valid(n);
    e = sb_q.pop_front();
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1'b1 || out_result !== e.res || in_ready !== 1'b0) bad++;
      tick();
    end
    checks++; if (bad != 0 || e.res !== 32'd7) begin errors++; $display("FAIL bp_hold bad_cycles got %0d want 0", bad); end
    in_op1 = 32'd1; in_op2 = 32'd2; in_func = F_ADD; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready got %b want 1", in_ready); end
    e.res = 32'd3; e.fl = exp_flags;
    sb_q.push_back(e);
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || alu_op1 !== 32'd1 || alu_op2 !== 32'd2) begin
      errors++; $display("FAIL bp_same_cycle_accept got v=%b op1=%h want v=0 op1=1", out_valid, alu_op1);
    end
    wait_valid(n);
    e = sb_q.pop_front();
    checks++; if (n != 1 || out_result !== e.res) begin
      errors++; $display("FAIL bp_next_result got %0d/%h want 1/%h", n, out_result, e.res);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int n;
    int t0;
    int t1;
    int bad;
    exp_t e;
    logic [31:0] a_tab [4] = '{32'd9, 32'd0, 32'h0000_00A0, 32'd0};
    logic [31:0] b_tab [4] = '{32'd3, 32'd0, 32'h0000_000B, 32'd0};
    logic [5:0]  f_tab [4] = '{F_SUB, F_BRFL, F_OR, F_NOT};
    out_ready = 1'b1;
    bad = 0; t0 = 0; t1 = 0;
    for (int i = 0; i < 4; i++) begin
      issue(a_tab[i], b_tab[i], f_tab[i]);
      wait_valid(n);
      e = sb_q.pop_front();
      if (i == 0) t0 = cyc;
      t1 = cyc;
      checks++; if (n != 1 || out_result !== e.res || flags !== e.fl) begin
        errors++; $display("FAIL b2b_op%0d got %0d/%h/%b want 1/%h/%b", i, n, out_result, flags, e.res, e.fl);
      end
    end
    checks++; if (t1 - t0 != 6) begin errors++; $display("FAIL b2b_throughput got %0d want 6", t1 - t0); end
    tick();
  endtask

  task automatic test_flags_clear();
    int n;
    exp_t e;
    out_ready = 1'b1;
    issue(32'h7FFF_FFFF, 32'h0000_0001, F_ADD);
    flags_clear = 1'b1;
    tick();
    flags_clear = 1'b0;
    exp_flags = 3'b000;
    e = sb_q.pop_front();
    checks++; if (out_valid !== 1'b1 || out_result !== 32'h8000_0000) begin
      errors++; $display("FAIL clr_result got v=%b %h want v=1 80000000", out_valid, out_result);
    end
    checks++; if (flags !== 3'b000) begin errors++; $display("FAIL clr_priority got %b want 000", flags); end
    tick();
    issue(32'd0, 32'd0, F_BRFL);
    wait_valid(n);
    e = sb_q.pop_front();
    checks++; if (out_result !== 32'd0 || e.res !== 32'd0) begin
      errors++; $display("FAIL clr_brfl got %h want 0", out_result);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int n;
    int seen;
    exp_t e;
    out_ready = 1'b1;
    issue(32'd5, 32'd5, F_SUB);
    wait_valid(n);
    e = sb_q.pop_front();
    tick();
    issue(32'd100, 32'd7, F_DIV);
    tick();
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || flags !== 3'b000) begin
      errors++; $display("FAIL rst_mid_immediate got v=%b f=%b want v=0 f=000", out_valid, flags);
    end
    e = sb_q.pop_front();
    exp_flags = 3'b000;
    @(posedge clk);
    #1 rst_n = 1'b1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_in_ready got %b want 1", in_ready); end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid !== 1'b0 || flags !== 3'b000) seen++;
      tick();
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL rst_mid_stale got %0d cycles want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_mul_hold();
    test_sub_and();
    test_unknown_func();
    test_backpressure();
    test_back_to_back();
    test_flags_clear();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
